ipa_gcm_arb: RTL and testbench

IPA_GCM_ARB -- requirements
Module: ipa_gcm_arb

---
 rtl/ipa_gcm_arb_if.sv | 49 ++++
 rtl/ipa_gcm_arb.sv | 105 ++++++++++
 tb/tb_ipa_gcm_arb.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipa_gcm_arb_if.sv
// Bus bundle for the GCM context/crossbar SRAM arbiter: context port, two crossbar
// bank ports and the two SRAM bank ports. The arbiter takes the slave side.
interface ipa_gcm_arb_if #(
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 20
);
    logic                                 ctx_req_i;
    logic [ADDR_MEM_WIDTH-1:0]            ctx_addr_i;
    logic                                 ctx_gnt_o;
    logic                                 ctx_rvalid_o;
    logic [2*DATA_WIDTH-1:0]              ctx_rdata_o;

    logic [1:0]                           xbar_req_i;
    logic [1:0]                           xbar_wen_i;
    logic [1:0][ADDR_MEM_WIDTH-1:0]       xbar_add_i;
    logic [1:0][DATA_WIDTH-1:0]           xbar_wdata_i;
    logic [1:0][3:0]                      xbar_be_i;
    logic [1:0][ID_WIDTH-1:0]             xbar_id_i;
    logic [1:0]                           xbar_gnt_o;
    logic [1:0]                           xbar_rvalid_o;
    logic [1:0][DATA_WIDTH-1:0]           xbar_rdata_o;
    logic [1:0][ID_WIDTH-1:0]             xbar_rid_o;

    logic [1:0]                           sram_req_o;
    logic [1:0]                           sram_wen_o;
    logic [1:0][ADDR_MEM_WIDTH-1:0]       sram_add_o;
    logic [1:0][DATA_WIDTH-1:0]           sram_wdata_o;
    logic [1:0][3:0]                      sram_be_o;
    logic [1:0][DATA_WIDTH-1:0]           sram_rdata_i;

    modport slave (
        input  ctx_req_i, ctx_addr_i,
        output ctx_gnt_o, ctx_rvalid_o, ctx_rdata_o,
        input  xbar_req_i, xbar_wen_i, xbar_add_i, xbar_wdata_i, xbar_be_i, xbar_id_i,
        output xbar_gnt_o, xbar_rvalid_o, xbar_rdata_o, xbar_rid_o,
        output sram_req_o, sram_wen_o, sram_add_o, sram_wdata_o, sram_be_o,
        input  sram_rdata_i
    );

    modport master (
        output ctx_req_i, ctx_addr_i,
        input  ctx_gnt_o, ctx_rvalid_o, ctx_rdata_o,
        output xbar_req_i, xbar_wen_i, xbar_add_i, xbar_wdata_i, xbar_be_i, xbar_id_i,
        input  xbar_gnt_o, xbar_rvalid_o, xbar_rdata_o, xbar_rid_o,
        input  sram_req_o, sram_wen_o, sram_add_o, sram_wdata_o, sram_be_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/ipa_gcm_arb.sv
// Two-bank SRAM arbiter: atomic dual-bank context reads take priority over the
// crossbar, with a stall counter that forces one crossbar cycle after MAX_STALL denials.
module ipa_gcm_arb #(
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 20,
    parameter int MAX_STALL      = 8
) (
    input  logic           clk,
    input  logic           rst,
    ipa_gcm_arb_if.slave   bus
);
    localparam logic [0:0] ST_NORMAL     = 1'b0;
    localparam logic [0:0] ST_FORCE_XBAR = 1'b1;
    localparam logic [7:0] MAX_STALL_C   = 8'(MAX_STALL);

    logic [0:0]                   state_q, state_d;
    logic [7:0]                   stall_cnt_q, stall_cnt_d;
    logic                         ctx_rvalid_q;
    logic [1:0]                   xbar_rvalid_q;
    logic [1:0][ID_WIDTH-1:0]     xbar_rid_q;

    logic                         force_xbar;
    logic                         any_xbar_req;
    logic                         ctx_gnt;
    logic [1:0]                   xbar_gnt;

    assign force_xbar   = (state_q == ST_FORCE_XBAR);
    assign any_xbar_req = |bus.xbar_req_i;

    // Grants are masked by rst so nothing reaches the SRAM while reset is held.
    assign ctx_gnt  = bus.ctx_req_i & ~force_xbar & ~rst;
    assign xbar_gnt = bus.xbar_req_i & {2{~ctx_gnt & ~rst}};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_FORCE_XBAR) begin
            state_d     = ST_NORMAL;
            stall_cnt_d = '0;
        end else if ((|xbar_gnt) || !any_xbar_req) begin
            stall_cnt_d = '0;
        end else if (ctx_gnt) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
            if (stall_cnt_q + 8'd1 == MAX_STALL_C) begin
                state_d = ST_FORCE_XBAR;
            end
        end
    end

    // A context grant owns both banks; otherwise each bank follows its crossbar port.
    always_comb begin
        bus.sram_req_o   = '0;
        bus.sram_wen_o   = '0;
        bus.sram_add_o   = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = '0;
        for (int b = 0; b < 2; b++) begin
            if (ctx_gnt) begin
                bus.sram_req_o[b]   = 1'b1;
                bus.sram_wen_o[b]   = 1'b1;
                bus.sram_add_o[b]   = bus.ctx_addr_i;
                bus.sram_be_o[b]    = 4'hF;
                bus.sram_wdata_o[b] = '0;
            end else if (!rst) begin
                bus.sram_req_o[b]   = xbar_gnt[b];
                bus.sram_wen_o[b]   = bus.xbar_wen_i[b];
                bus.sram_add_o[b]   = bus.xbar_add_i[b];
                bus.sram_be_o[b]    = bus.xbar_be_i[b];
                bus.sram_wdata_o[b] = bus.xbar_wdata_i[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            stall_cnt_q   <= '0;
            ctx_rvalid_q  <= 1'b0;
            xbar_rvalid_q <= '0;
            // NOTE: the ID register is reset too, because xbar_rid_o must read zero under reset.
            xbar_rid_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            ctx_rvalid_q  <= ctx_gnt;
            xbar_rvalid_q <= xbar_gnt;
            for (int b = 0; b < 2; b++) begin
                if (xbar_gnt[b]) begin
                    xbar_rid_q[b] <= bus.xbar_id_i[b];
                end
            end
        end
    end

    assign bus.ctx_gnt_o     = ctx_gnt;
    assign bus.xbar_gnt_o    = xbar_gnt;
    assign bus.ctx_rvalid_o  = ctx_rvalid_q;
    assign bus.xbar_rvalid_o = xbar_rvalid_q;
    assign bus.xbar_rid_o    = xbar_rid_q;
    assign bus.ctx_rdata_o   = rst ? '0 : {bus.sram_rdata_i[0], bus.sram_rdata_i[1]};
    assign bus.xbar_rdata_o  = rst ? '0 : bus.sram_rdata_i;
endmodule

// File: tb/tb_ipa_gcm_arb.sv
// Self-checking bench for ipa_gcm_arb: a reference arbitration model predicts grants,
// and a response scoreboard checks rvalid/rid/rdata one cycle after each grant.
module tb_ipa_gcm_arb;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 20;
    localparam int MS = 8;

    typedef struct packed {
        logic                 ctx_v;
        logic [1:0]           x_v;
        logic [1:0][IW-1:0]   id;
        logic [2*DW-1:0]      ctx_data;
        logic [1:0][DW-1:0]   xdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipa_gcm_arb_if #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    ipa_gcm_arb #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_STALL(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bench-side SRAM: returns the pre-write word one cycle after each access.
    logic [DW-1:0]          mem [2][4096];
    logic [1:0][DW-1:0]     rd_q;
    assign bus.sram_rdata_i = rd_q;

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (bus.sram_req_o[b]) begin
                rd_q[b] <= mem[b][bus.sram_add_o[b]];
                if (!bus.sram_wen_o[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.sram_be_o[b][k]) mem[b][bus.sram_add_o[b]][8*k +: 8] <= bus.sram_wdata_o[b][8*k +: 8];
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    resp_t sb[$];

    // Reference arbitration state
    logic       force_m = 1'b0;
    int         denied_m = 0;

    logic              obs_ctx_gnt, obs_ctx_rv;
    logic [1:0]        obs_x_gnt, obs_x_rv, obs_sram_req, obs_sram_wen;
    logic [2*DW-1:0]   obs_ctx_rdata;
    logic [IW-1:0]     obs_rid0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.ctx_req_i    = 1'b0;
        bus.ctx_addr_i   = '0;
        bus.xbar_req_i   = '0;
        bus.xbar_wen_i   = 2'b11;
        bus.xbar_add_i   = '0;
        bus.xbar_wdata_i = '0;
        bus.xbar_be_i    = '0;
        bus.xbar_id_i    = '0;
    endtask

    task automatic drive_x(input int b, input logic wen, input logic [AW-1:0] add,
                           input logic [DW-1:0] wdata, input logic [3:0] be, input logic [IW-1:0] id);
        bus.xbar_req_i[b]   = 1'b1;
        bus.xbar_wen_i[b]   = wen;
        bus.xbar_add_i[b]   = add;
        bus.xbar_wdata_i[b] = wdata;
        bus.xbar_be_i[b]    = be;
        bus.xbar_id_i[b]    = id;
    endtask

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic       exp_ctx;
        logic [1:0] exp_x;
        resp_t      exp_r, nxt;
        @(negedge clk);
        if (rst) begin
            force_m  = 1'b0;
            denied_m = 0;
            sb.delete();
        end
        exp_ctx = bus.ctx_req_i & ~force_m & ~rst;
        exp_x   = rst ? 2'b00 : (bus.xbar_req_i & {2{~exp_ctx}});
        check("ctx_gnt", bus.ctx_gnt_o, exp_ctx);
        check("xbar_gnt", bus.xbar_gnt_o, exp_x);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("sram_req%0d", b), bus.sram_req_o[b], exp_ctx | exp_x[b]);
            if (exp_ctx) begin
                check($sformatf("ctx_sram_wen%0d", b), bus.sram_wen_o[b], 1'b1);
                check($sformatf("ctx_sram_add%0d", b), bus.sram_add_o[b], bus.ctx_addr_i);
                check($sformatf("ctx_sram_be%0d", b), bus.sram_be_o[b], 4'hF);
                check($sformatf("ctx_sram_wdata%0d", b), bus.sram_wdata_o[b], '0);
            end else if (exp_x[b]) begin
                check($sformatf("x_sram_wen%0d", b), bus.sram_wen_o[b], bus.xbar_wen_i[b]);
                check($sformatf("x_sram_add%0d", b), bus.sram_add_o[b], bus.xbar_add_i[b]);
                check($sformatf("x_sram_be%0d", b), bus.sram_be_o[b], bus.xbar_be_i[b]);
                check($sformatf("x_sram_wdata%0d", b), bus.sram_wdata_o[b], bus.xbar_wdata_i[b]);
            end else if (rst) begin
                check($sformatf("rst_sram_fields%0d", b),
                      {bus.sram_wen_o[b], bus.sram_add_o[b], bus.sram_be_o[b], bus.sram_wdata_o[b]}, '0);
            end
        end

        exp_r = (rst || sb.size() == 0) ? resp_t'('0) : sb.pop_front();
        check("ctx_rvalid", bus.ctx_rvalid_o, exp_r.ctx_v);
        check("xbar_rvalid", bus.xbar_rvalid_o, exp_r.x_v);
        if (exp_r.ctx_v) check("ctx_rdata", bus.ctx_rdata_o, exp_r.ctx_data);
        for (int b = 0; b < 2; b++) begin
            if (exp_r.x_v[b]) begin
                check($sformatf("rid%0d", b), bus.xbar_rid_o[b], exp_r.id[b]);
                check($sformatf("rdata%0d", b), bus.xbar_rdata_o[b], exp_r.xdata[b]);
            end
        end
        if (rst) begin
            check("rst_rdata", {bus.ctx_rdata_o, bus.xbar_rdata_o}, '0);
            check("rst_rid", bus.xbar_rid_o, '0);
        end

        obs_ctx_gnt   = bus.ctx_gnt_o;
        obs_x_gnt     = bus.xbar_gnt_o;
        obs_sram_req  = bus.sram_req_o;
        obs_sram_wen  = bus.sram_wen_o;
        obs_ctx_rv    = bus.ctx_rvalid_o;
        obs_x_rv      = bus.xbar_rvalid_o;
        obs_ctx_rdata = bus.ctx_rdata_o;
        obs_rid0      = bus.xbar_rid_o[0];

        if (!rst) begin
            nxt.ctx_v    = exp_ctx;
            nxt.x_v      = exp_x;
            nxt.id       = bus.xbar_id_i;
            nxt.ctx_data = {mem[0][bus.ctx_addr_i], mem[1][bus.ctx_addr_i]};
            for (int b = 0; b < 2; b++) nxt.xdata[b] = mem[b][bus.xbar_add_i[b]];
            sb.push_back(nxt);
        end

        @(posedge clk);
        if (!rst) begin
            if (force_m) begin
                force_m  = 1'b0;
                denied_m = 0;
            end else if (exp_ctx && (|bus.xbar_req_i)) begin
                denied_m++;
                if (denied_m == MS) force_m = 1'b1;
            end else begin
                denied_m = 0;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[0][i] = 32'h0A00_0000 | 32'(i);
            mem[1][i] = 32'h0B00_0000 | 32'(i);
        end
        mem[0][12'h020] = 32'h1111_1111;
        mem[1][12'h020] = 32'h2222_2222;
        rd_q = '0;

        // Reset held with requests present: everything must stay at zero.
        set_idle();
        bus.ctx_req_i  = 1'b1;
        bus.xbar_req_i = 2'b11;
        tick();
        check("rst_ctx_gnt", obs_ctx_gnt, 1'b0);
        check("rst_sram_req", obs_sram_req, 2'b00);
        rst = 1'b0;
        set_idle();
        tick();
        check("idle_sram_req", obs_sram_req, 2'b00);

        // Crossbar write on bank 0
        drive_x(0, 1'b0, 12'h010, 32'hA5A5_A5A5, 4'hF, 20'h3);
        tick();
        check("wr_gnt", obs_x_gnt, 2'b01);
        check("wr_sram_wen", obs_sram_wen, 2'b10);
        set_idle();
        tick();
        check("wr_rvalid", obs_x_rv, 2'b01);
        check("wr_rid", obs_rid0, 20'h3);

        // Read the written word back
        drive_x(0, 1'b1, 12'h010, '0, 4'hF, 20'h7);
        tick();
        set_idle();
        tick();
        check("rdback_data_mem", mem[0][12'h010], 32'hA5A5_A5A5);

        // Context read
        bus.ctx_req_i  = 1'b1;
        bus.ctx_addr_i = 12'h020;
        tick();
        check("ctx_gnt_lit", obs_ctx_gnt, 1'b1);
        check("ctx_sram_req_lit", obs_sram_req, 2'b11);
        set_idle();
        tick();
        check("ctx_rvalid_lit", obs_ctx_rv, 1'b1);
        check("ctx_rdata_lit", obs_ctx_rdata, 64'h1111_1111_2222_2222);

        // Simultaneous context and both crossbar banks
        bus.ctx_req_i = 1'b1;
        drive_x(0, 1'b1, 12'h100, '0, 4'hF, 20'h10);
        drive_x(1, 1'b1, 12'h101, '0, 4'hF, 20'h11);
        tick();
        check("simul_ctx", obs_ctx_gnt, 1'b1);
        check("simul_xbar", obs_x_gnt, 2'b00);
        set_idle();
        tick();

        // Back-to-back crossbar traffic on both banks
        for (int i = 0; i < 6; i++) begin
            drive_x(0, 1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom), 20'($urandom));
            drive_x(1, 1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom), 20'($urandom));
            tick();
            check("b2b_gnt", obs_x_gnt, 2'b11);
        end
        set_idle();
        tick();

        // Starvation: ctx wins 8 cycles, crossbar bank 1 gets cycle 9, ctx again in 10
        for (int i = 1; i <= 10; i++) begin
            bus.ctx_req_i  = 1'b1;
            bus.ctx_addr_i = 12'(i);
            drive_x(1, 1'b1, 12'(40 + i), '0, 4'hF, 20'(i));
            tick();
            check($sformatf("starve_ctx_c%0d", i), obs_ctx_gnt, (i == 9) ? 1'b0 : 1'b1);
            check($sformatf("starve_x_c%0d", i), obs_x_gnt, (i == 9) ? 2'b10 : 2'b00);
        end
        set_idle();
        tick();

        // Forced crossbar cycle with no crossbar request still blocks the context
        for (int i = 1; i <= 10; i++) begin
            set_idle();
            bus.ctx_req_i = 1'b1;
            if (i <= 8) drive_x(0, 1'b1, 12'(i), '0, 4'hF, 20'(i));
            tick();
            check($sformatf("force_ctx_c%0d", i), obs_ctx_gnt, (i == 9) ? 1'b0 : 1'b1);
        end
        set_idle();
        tick();

        // Reset in the cycle after a grant drops the outstanding response
        drive_x(0, 1'b1, 12'h055, '0, 4'hF, 20'hABC);
        tick();
        check("pre_rst_gnt", obs_x_gnt, 2'b01);
        set_idle();
        rst = 1'b1;
        tick();
        check("rst_drop_rvalid", obs_x_rv, 2'b00);
        rst = 1'b0;
        tick();
        check("post_rst_rvalid", {obs_ctx_rv, obs_x_rv}, 3'b000);
        drive_x(1, 1'b1, 12'h066, '0, 4'hF, 20'h5);
        tick();
        check("post_rst_gnt", obs_x_gnt, 2'b10);
        set_idle();
        tick();

        // Random mix of context and crossbar traffic
        for (int i = 0; i < 60; i++) begin
            set_idle();
            bus.ctx_req_i  = 1'($urandom_range(0, 3) != 0);
            bus.ctx_addr_i = 12'($urandom);
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 2) != 0)
                    drive_x(b, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom, 4'($urandom), 20'($urandom));
            end
            tick();
        end
        set_idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
